// File: rtl/isa_loader_pkg.sv
// Shared types and helpers for the instruction memory loader.
// The CSUM state exists only when LOADER_CHECKSUM_EN is defined.
package isa_loader_pkg;
  localparam int DATA_W = 16;
  localparam int BYTE_W = 8;
  localparam int LEN_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HI   = 3'd1,
    ST_LO   = 3'd2,
    ST_WR   = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    ST_CSUM = 3'd4,
`endif
    ST_DONE = 3'd5
  } state_t;

  function automatic logic [LEN_W-1:0] clampLen(input logic [LEN_W-1:0] len, input int depth);
    logic [LEN_W-1:0] clamped;
    clamped = len;
    if (int'(len) > depth) clamped = LEN_W'(depth);
    return clamped;
  endfunction
endpackage

// File: rtl/loader_csum.sv
// 8-bit running byte sum (mod 256) with clear, add-enable and a check that
// the sum plus the presented byte is zero. Used only with LOADER_CHECKSUM_EN.
module loader_csum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_add,
  input  logic [7:0] i_byte,
  output logic       o_zero
);
  logic [7:0] r_sum;
  logic [7:0] w_total;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_sum <= '0;
    else if (i_clr) r_sum <= '0;
    else if (i_add) r_sum <= r_sum + i_byte;
  end

  assign w_total = r_sum + i_byte;
  assign o_zero  = (w_total == 8'd0);
endmodule

// File: rtl/instr_mem_loader.sv
// Loads a 16-bit instruction image from a byte stream into instruction memory.
// Optional trailing checksum byte when LOADER_CHECKSUM_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// HI    | waiting for high byte
// LO    | waiting for low byte
// WR    | one memory write cycle
// CSUM  | waiting for checksum byte (LOADER_CHECKSUM_EN only)
// DONE  | load complete, waiting for start
module instr_mem_loader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = isa_loader_pkg::DATA_W,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4:0]        loadLen,
  input  logic              byteValid,
  input  logic [7:0]        byteData,
  output logic              byteReady,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAdr,
  output logic [DATA_W-1:0] memData,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import isa_loader_pkg::*;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_adr, r_len;
  logic [DATA_W-1:0] r_word;
  logic              r_we;
  logic [LEN_W-1:0]  w_len_clamped;
  logic              w_start_ok, w_xfer, w_last;

  assign w_len_clamped = clampLen(loadLen, DEPTH);
  assign w_start_ok    = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_xfer        = byteValid && byteReady;
  assign w_last        = (r_adr + ADDR_W'(1)) == r_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    byteReady = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        busy = 1'b0;
        done = (r_state == ST_DONE);
        if (start) w_next = (w_len_clamped == '0) ? ST_DONE : ST_HI;
      end
      ST_HI: begin
        byteReady = 1'b1;
        if (byteValid) w_next = ST_LO;
      end
      ST_LO: begin
        byteReady = 1'b1;
        if (byteValid) w_next = ST_WR;
      end
      ST_WR: begin
        if (w_last) begin
`ifdef LOADER_CHECKSUM_EN
          w_next = ST_CSUM;
`else
          w_next = ST_DONE;
`endif
        end else begin
          w_next = ST_HI;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM: begin
        byteReady = 1'b1;
        if (byteValid) w_next = ST_DONE;
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  // Write strobe is a flop so memory sees a clean single-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we   <= 1'b0;
      r_adr  <= '0;
      r_len  <= '0;
      r_word <= '0;
    end else begin
      r_we <= (w_next == ST_WR);
      if (w_start_ok) begin
        r_adr <= '0;
        r_len <= ADDR_W'(w_len_clamped);
      end else if (r_state == ST_WR) begin
        r_adr <= r_adr + ADDR_W'(1);
      end
      if (r_state == ST_HI && w_xfer) r_word[DATA_W-1:BYTE_W] <= byteData;
      if (r_state == ST_LO && w_xfer) r_word[BYTE_W-1:0]      <= byteData;
    end
  end

  assign memWe   = r_we;
  assign memAdr  = r_adr;
  assign memData = r_word;

`ifdef LOADER_CHECKSUM_EN
  logic w_csum_zero;
  logic r_err;

  loader_csum u_csum (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_start_ok),
    .i_add  (w_xfer && (r_state == ST_HI || r_state == ST_LO)),
    .i_byte (byteData),
    .o_zero (w_csum_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_err <= 1'b0;
    else if (w_start_ok)                    r_err <= 1'b0;
    else if (r_state == ST_CSUM && w_xfer)  r_err <= !w_csum_zero;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif
endmodule
